// File: rtl/sound_sequencer.sv
// rtl/sound_sequencer.sv - queued note player driving the one-bit beeper command port
// Optional abort strobe with queue flush is enabled by defining SOUND_SEQ_ABORT_EN.
module sound_sequencer #(
  parameter int TICK_DIV   = 100000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [15:0]                   wr_data,
`ifdef SOUND_SEQ_ABORT_EN
  input  logic                          abort,
`endif
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          snd_data_tx,
  output logic [8:0]                    snd_data,
  output logic                          snd_enable
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    TONE,
    ENABLE,
    PLAY,
    STOP
  } state_t;

  state_t state, next_state;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [15:0]   head;
  logic          pop, push, abort_i, play_done;
  logic [7:0]    tone_r;
  logic [7:0]    dur_cnt;
  logic [PW-1:0] pre_cnt;

`ifdef SOUND_SEQ_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign head      = mem[rd_ptr];
  assign fifo_full = (fifo_level == DEPTH_L);
  assign busy      = (state != IDLE) || (fifo_level != '0);
  // A full queue still accepts a write when the head is popped in the same cycle.
  assign push      = wr_en && !abort_i && (!fifo_full || pop);

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    play_done  = (pre_cnt == PRE_LAST) && (dur_cnt == 8'd1);
    unique case (state)
      IDLE: begin
        if (fifo_level != '0) begin
          pop = 1'b1;
          if (head[7:0] == 8'd0)       next_state = IDLE;
          else if (head[15:8] == 8'd0) next_state = PLAY;
          else                         next_state = TONE;
        end
      end
      TONE:    next_state = ENABLE;
      ENABLE:  next_state = PLAY;
      PLAY: begin
        if (play_done) next_state = (tone_r != 8'd0) ? STOP : IDLE;
      end
      STOP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort_i) begin
      pop = 1'b0;
      if (state == TONE || state == ENABLE || (state == PLAY && tone_r != 8'd0))
        next_state = STOP;
      else
        next_state = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else if (abort_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (wr_en && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  // Tick count is loaded at pop and only consumed in PLAY; the prescaler idles at 0 elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tone_r  <= '0;
      dur_cnt <= '0;
      pre_cnt <= '0;
    end else begin
      if (pop) begin
        tone_r  <= head[15:8];
        dur_cnt <= head[7:0];
      end else if (state == PLAY && pre_cnt == PRE_LAST && dur_cnt != 8'd0) begin
        dur_cnt <= dur_cnt - 8'd1;
      end
      if (state == PLAY && pre_cnt != PRE_LAST) pre_cnt <= pre_cnt + 1'b1;
      else                                      pre_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snd_data_tx <= 1'b0;
      snd_data    <= '0;
      snd_enable  <= 1'b0;
    end else begin
      snd_data_tx <= (next_state == TONE) || (next_state == STOP);
      snd_data    <= (next_state == TONE) ? {1'b1, head[15:8]} : 9'h000;
      snd_enable  <= (next_state == ENABLE);
    end
  end

endmodule

// File: tb/tb_sound_sequencer.sv
// tb/tb_sound_sequencer.sv - scoreboard bench for sound_sequencer with TICK_DIV=4
module tb_sound_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
`ifdef SOUND_SEQ_ABORT_EN
  logic        abort;
`endif
  logic        fifo_full;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        busy;
  logic        snd_data_tx;
  logic [8:0]  snd_data;
  logic        snd_enable;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    int         cyc;
    logic       en;
    logic [8:0] data;
  } ev_t;

  ev_t exp_q[$];

  sound_sequencer #(.TICK_DIV(4), .FIFO_DEPTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
`ifdef SOUND_SEQ_ABORT_EN
    .abort       (abort),
`endif
    .fifo_full   (fifo_full),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .busy        (busy),
    .snd_data_tx (snd_data_tx),
    .snd_data    (snd_data),
    .snd_enable  (snd_enable)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int c, input logic en, input logic [8:0] d);
    ev_t e;
    e.cyc  = c;
    e.en   = en;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [15:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!reset && (snd_data_tx || snd_enable)) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_ev: cyc=%0d tx=%0b en=%0b data=%h", cyc, snd_data_tx, snd_enable, snd_data);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || snd_enable !== e.en || snd_data_tx !== !e.en || snd_data !== e.data) begin
          mismatched++;
          $display("FAIL beeper_ev: got cyc=%0d tx=%0b en=%0b data=%h expected cyc=%0d en=%0b data=%h",
                   cyc, snd_data_tx, snd_enable, snd_data, e.cyc, e.en, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
`ifdef SOUND_SEQ_ABORT_EN
    abort   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_level", fifo_level, 0);
    chk("rst_outputs", {snd_data_tx, snd_enable, snd_data, busy, overflow, fifo_full}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // single tone 0x10, 3 ticks
    n = cyc;
    expect_ev(n + 2, 1'b0, 9'h110);
    expect_ev(n + 3, 1'b1, 9'h000);
    expect_ev(n + 16, 1'b0, 9'h000);
    wr(16'h1003);
    chk("t1_level", fifo_level, 1);
    chk("t1_busy_start", busy, 1);
    wait_until(n + 16);
    chk("t1_busy_stop", busy, 1);
    wait_until(n + 17);
    chk("t1_busy_end", busy, 0);

    // rest of 2 ticks: silent, busy for 9 cycles
    n = cyc;
    wr(16'h0002);
    chk("rest_busy_first", busy, 1);
    wait_until(n + 9);
    chk("rest_busy_last", busy, 1);
    wait_until(n + 10);
    chk("rest_busy_end", busy, 0);

    // zero duration entry is discarded
    n = cyc;
    wr(16'h2000);
    chk("zero_level_in", fifo_level, 1);
    wait_until(n + 2);
    chk("zero_level_out", fifo_level, 0);
    chk("zero_busy", busy, 0);

    // back-to-back notes with write coinciding with pop
    n = cyc;
    expect_ev(n + 2, 1'b0, 9'h130);
    expect_ev(n + 3, 1'b1, 9'h000);
    expect_ev(n + 8, 1'b0, 9'h000);
    expect_ev(n + 10, 1'b0, 9'h140);
    expect_ev(n + 11, 1'b1, 9'h000);
    expect_ev(n + 16, 1'b0, 9'h000);
    wr(16'h3001);
    wr(16'h4001);
    chk("b2b_level", fifo_level, 1);
    wait_until(n + 17);
    chk("b2b_busy_end", busy, 0);

    // long note, then 17 writes while it plays
    n = cyc;
    expect_ev(n + 2, 1'b0, 9'h150);
    expect_ev(n + 3, 1'b1, 9'h000);
    expect_ev(n + 68, 1'b0, 9'h000);
    for (int k = 0; k < 16; k++) begin
      expect_ev(n + 70 + 8 * k, 1'b0, {1'b1, 8'h60 + 8'(k)});
      expect_ev(n + 71 + 8 * k, 1'b1, 9'h000);
      expect_ev(n + 76 + 8 * k, 1'b0, 9'h000);
    end
    wr(16'h5010);
    wait_until(n + 4);
    for (int k = 0; k < 17; k++) begin
      wr({8'h60 + 8'(k), 8'h01});
      if (k == 15) begin
        chk("ovf_full", fifo_full, 1);
        chk("ovf_level16", fifo_level, 16);
        chk("ovf_not_yet", overflow, 0);
      end
    end
    chk("ovf_set", overflow, 1);
    chk("ovf_level_kept", fifo_level, 16);
    wait_until(n + 196);
    chk("ovf_busy_last", busy, 1);
    wait_until(n + 197);
    chk("ovf_busy_end", busy, 0);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_not_full", fifo_full, 0);

    // reset during PLAY with a queued entry
    n = cyc;
    expect_ev(n + 2, 1'b0, 9'h170);
    expect_ev(n + 3, 1'b1, 9'h000);
    wr(16'h7005);
    wr(16'h7105);
    wait_until(n + 6);
    chk("pre_rst_level", fifo_level, 1);
    reset = 1'b1;
    #1;
    chk("midrst_level", fifo_level, 0);
    chk("midrst_outputs", {snd_data_tx, snd_enable, snd_data, busy, overflow, fifo_full}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_stop", exp_q.size(), 0);

`ifdef SOUND_SEQ_ABORT_EN
    // abort in PLAY sends STOP next cycle and flushes the queue
    n = cyc;
    expect_ev(n + 2, 1'b0, 9'h172);
    expect_ev(n + 3, 1'b1, 9'h000);
    expect_ev(n + 7, 1'b0, 9'h000);
    wr(16'h7203);
    wr(16'h7301);
    wait_until(n + 6);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_flush", fifo_level, 0);
    wait_until(n + 8);
    chk("abort_busy_end", busy, 0);
`endif

    repeat (4) @(negedge clk);
    chk("exp_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
